// File: rtl/emit_multi_if.sv
// Handshake bundle between an emit controller master and the emit_multi channel bank.
interface emit_multi_if #(
    parameter int unsigned NCH = 4,
    parameter int unsigned CW  = 8,
    parameter int unsigned SW  = 2
) ();
    logic           load;
    logic [SW-1:0]  load_ch;
    logic [CW-1:0]  load_val;
    logic [NCH-1:0] out_ctrl;
    logic           tick;
    logic [NCH-1:0] abort;
    logic [NCH-1:0] count_ACK;
    logic [NCH-1:0] out;
    logic [NCH-1:0] count_req;
    logic [NCH-1:0] busy;
    logic           load_err;

    modport master (
        output load, load_ch, load_val, out_ctrl, tick, abort, count_ACK,
        input  out, count_req, busy, load_err
    );

    modport slave (
        input  load, load_ch, load_val, out_ctrl, tick, abort, count_ACK,
        output out, count_req, busy, load_err
    );
endinterface

// File: rtl/emit_multi.sv
// Bank of NCH independent timed-emit channels: load a length, start, emit for
// that many ticks, then request/acknowledge completion downstream.
module emit_multi #(
    parameter int unsigned NCH = 4,
    parameter int unsigned CW  = 8,
    parameter int unsigned SW  = 2
) (
    input  logic        clk,
    input  logic        RESET,
    emit_multi_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOADED = 2'd1,
        EMIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t         st     [NCH];
    state_t         st_nxt [NCH];
    logic [CW-1:0]  cnt     [NCH];
    logic [CW-1:0]  cnt_nxt [NCH];
    logic           ch_ok;
    logic           tgt_idle;
    logic           load_acc;
    logic           load_rej;

    // Load qualification: legal channel, non-zero length, target idle.
    always_comb begin
        ch_ok    = 32'(bus.load_ch) < NCH;
        tgt_idle = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (32'(bus.load_ch) == i && st[i] == IDLE) tgt_idle = 1'b1;
        end
        load_acc = bus.load && ch_ok && (bus.load_val != '0) && tgt_idle;
        load_rej = bus.load && !load_acc;
    end

    // Per-channel next state; abort overrides everything else on its channel.
    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            st_nxt[i]  = st[i];
            cnt_nxt[i] = cnt[i];
            if (bus.abort[i]) begin
                st_nxt[i]  = IDLE;
                cnt_nxt[i] = '0;
            end else begin
                case (st[i])
                    IDLE: begin
                        if (load_acc && 32'(bus.load_ch) == i) begin
                            st_nxt[i]  = LOADED;
                            cnt_nxt[i] = bus.load_val;
                        end
                    end
                    LOADED: begin
                        if (bus.out_ctrl[i]) st_nxt[i] = EMIT;
                    end
                    EMIT: begin
                        // Decrement only while non-zero, so cnt cannot wrap.
                        if (bus.tick && cnt[i] != '0) begin
                            if (cnt[i] == CW'(1)) begin
                                st_nxt[i]  = DONE;
                                cnt_nxt[i] = '0;
                            end else begin
                                cnt_nxt[i] = cnt[i] - CW'(1);
                            end
                        end
                    end
                    DONE: begin
                        if (bus.count_ACK[i]) st_nxt[i] = IDLE;
                    end
                    default: begin
                        st_nxt[i]  = IDLE;
                        cnt_nxt[i] = '0;
                    end
                endcase
            end
        end
    end

    // State and registered outputs, decoded from the upcoming state.
    always_ff @(posedge clk) begin
        if (RESET) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                st[i]  <= IDLE;
                cnt[i] <= '0;
            end
            bus.out       <= '0;
            bus.count_req <= '0;
            bus.busy      <= '0;
            bus.load_err  <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                st[i]            <= st_nxt[i];
                cnt[i]           <= cnt_nxt[i];
                bus.out[i]       <= (st_nxt[i] == EMIT);
                bus.count_req[i] <= (st_nxt[i] == DONE);
                bus.busy[i]      <= (st_nxt[i] != IDLE);
            end
            bus.load_err <= load_rej;
        end
    end

endmodule
